uart_transceiver: RTL and testbench

- Single-clock UART block containing a transmitter (uartTransmiter function) and a receiver (uartReceiber function).
- Format: 8N1, LSB first, idle-high line, fixed baud set by CLKS_PER_BIT.
- Sits between the system-clock fabric and external serial pins.
- TX and RX are fully independent and share only clk/rst_n.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_receiber.sv | 109 ++++++++++
 rtl/uart_transmiter.sv | 112 +++++++++++
 rtl/uart_transceiver.sv | 42 ++++
 tb/tb_uart_transceiver.sv | 354 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter and receiver.
//   uart_state_e : common 5-state frame FSM encoding (IDLE..CLEANUP)
//   DATA_BITS    : payload bits per frame (8N1)
//   cnt_width()  : bit-period counter width for a given CLKS_PER_BIT
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
    ST_STOP    = 3'd3,
    ST_CLEANUP = 3'd4
  } uart_state_e;

  localparam int unsigned DATA_BITS = 8;

  function automatic int unsigned cnt_width(input int unsigned clks_per_bit);
    return $clog2(clks_per_bit);
  endfunction

endpackage

// File: rtl/uart_receiber.sv
// 8N1 UART receiver with 2-flop input synchronizer and mid-bit sampling.
//   clk, rst_n    : system clock, async active-low reset
//   rx_serial     : asynchronous serial input
//   rx_data_valid : one-cycle pulse at mid stop bit
//   rx_byte       : received byte, filled bit by bit, held between frames
module uart_receiber
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_serial,
  output logic       rx_data_valid,
  output logic [7:0] rx_byte
);

  localparam int unsigned CW = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  logic [1:0]           sync;
  logic                 rx_s;
  uart_state_e          state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [2:0]           idx, idx_n;
  logic [DATA_BITS-1:0] byte_n;
  logic                 valid_n;
  logic                 armed, armed_n;

  assign rx_s = sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync          <= '1;
      state         <= ST_IDLE;
      cnt           <= '0;
      idx           <= '0;
      armed         <= 1'b0;
      rx_byte       <= '0;
      rx_data_valid <= 1'b0;
    end else begin
      sync          <= {sync[0], rx_serial};
      state         <= state_n;
      cnt           <= cnt_n;
      idx           <= idx_n;
      armed         <= armed_n;
      rx_byte       <= byte_n;
      rx_data_valid <= valid_n;
    end
  end

  // A start bit is only accepted after the line has been seen idle-high in
  // IDLE, so a line stuck low yields one 8'h00 frame and then waits.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    armed_n = armed;
    byte_n  = rx_byte;
    valid_n = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_n = '0;
        idx_n = '0;
        if (rx_s) begin
          armed_n = 1'b1;
        end else if (armed) begin
          armed_n = 1'b0;
          state_n = ST_START;
        end
      end
      ST_START: begin
        if (cnt == CNT_HALF) begin
          cnt_n   = '0;
          state_n = rx_s ? ST_IDLE : ST_DATA;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      ST_DATA: begin
        if (cnt != CNT_LAST) begin
          cnt_n = cnt + CW'(1);
        end else begin
          cnt_n       = '0;
          byte_n[idx] = rx_s;
          if (idx != 3'd7) begin
            idx_n = idx + 3'd1;
          end else begin
            idx_n   = '0;
            state_n = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        if (cnt != CNT_LAST) begin
          cnt_n = cnt + CW'(1);
        end else begin
          cnt_n   = '0;
          valid_n = 1'b1;
          state_n = ST_CLEANUP;
        end
      end
      ST_CLEANUP: state_n = ST_IDLE;
      default:    state_n = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_transmiter.sv
// 8N1 UART transmitter, LSB first, idle-high line.
//   clk, rst_n     : system clock, async active-low reset
//   tx_data_valid  : one-cycle send request, honoured only in IDLE
//   tx_byte        : byte latched on acceptance
//   tx_active      : high from acceptance until the frame completes
//   tx_serial      : serial line (registered)
//   tx_done        : one-cycle pulse after the stop bit
module uart_transmiter
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_data_valid,
  input  logic [7:0] tx_byte,
  output logic       tx_active,
  output logic       tx_serial,
  output logic       tx_done
);

  localparam int unsigned CW = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  uart_state_e          state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [2:0]           idx, idx_n;
  logic [DATA_BITS-1:0] data, data_n;
  logic                 serial_n, active_n, done_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      idx       <= '0;
      data      <= '0;
      tx_serial <= 1'b1;
      tx_active <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      data      <= data_n;
      tx_serial <= serial_n;
      tx_active <= active_n;
      tx_done   <= done_n;
    end
  end

  // The serial line is registered, so each transition loads the level of the
  // bit being entered rather than the one being left.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    idx_n    = idx;
    data_n   = data;
    serial_n = tx_serial;
    active_n = tx_active;
    done_n   = 1'b0;
    case (state)
      ST_IDLE: begin
        serial_n = 1'b1;
        cnt_n    = '0;
        idx_n    = '0;
        if (tx_data_valid) begin
          data_n   = tx_byte;
          active_n = 1'b1;
          serial_n = 1'b0;
          state_n  = ST_START;
        end
      end
      ST_START: begin
        if (cnt != CNT_LAST) begin
          cnt_n = cnt + CW'(1);
        end else begin
          cnt_n    = '0;
          serial_n = data[0];
          state_n  = ST_DATA;
        end
      end
      ST_DATA: begin
        if (cnt != CNT_LAST) begin
          cnt_n = cnt + CW'(1);
        end else begin
          cnt_n = '0;
          if (idx != 3'd7) begin
            idx_n    = idx + 3'd1;
            serial_n = data[idx_n];
          end else begin
            idx_n    = '0;
            serial_n = 1'b1;
            state_n  = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        if (cnt != CNT_LAST) begin
          cnt_n = cnt + CW'(1);
        end else begin
          cnt_n    = '0;
          done_n   = 1'b1;
          active_n = 1'b0;
          state_n  = ST_CLEANUP;
        end
      end
      ST_CLEANUP: state_n = ST_IDLE;
      default:    state_n = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_transceiver.sv
// UART transceiver: independent 8N1 transmitter and receiver sharing clk/rst_n.
//   clk, rst_n                          : system clock, async active-low reset
//   tx_data_valid, tx_byte              : transmit request and byte
//   tx_active, tx_serial, tx_done       : transmit status and line
//   rx_serial                           : receive line (asynchronous)
//   rx_data_valid, rx_byte              : received byte and strobe
module uart_transceiver
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_data_valid,
  input  logic [7:0] tx_byte,
  output logic       tx_active,
  output logic       tx_serial,
  output logic       tx_done,
  input  logic       rx_serial,
  output logic       rx_data_valid,
  output logic [7:0] rx_byte
);

  uart_transmiter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk           (clk),
    .rst_n         (rst_n),
    .tx_data_valid (tx_data_valid),
    .tx_byte       (tx_byte),
    .tx_active     (tx_active),
    .tx_serial     (tx_serial),
    .tx_done       (tx_done)
  );

  uart_receiber #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx_serial     (rx_serial),
    .rx_data_valid (rx_data_valid),
    .rx_byte       (rx_byte)
  );

endmodule

// File: tb/tb_uart_transceiver.sv
module tb_uart_transceiver;

  localparam int unsigned CPB = 16;
  localparam int unsigned FL  = 10 * CPB + 1;
  localparam logic [FL-1:0] ACT_EXP  = {1'b0, {(FL-1){1'b1}}};
  localparam logic [FL-1:0] DONE_EXP = {1'b1, {(FL-1){1'b0}}};

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       tx_data_valid = 1'b0;
  logic [7:0] tx_byte = 8'h00;
  logic       rx_drv = 1'b1;
  logic       loop_en = 1'b0;
  logic       rx_line;
  logic       tx_active, tx_serial, tx_done, rx_data_valid;
  logic [7:0] rx_byte;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [7:0] tx_exp[$];
  logic [7:0] rx_exp[$];
  logic [7:0] rx_got[$];
  int         rx_got_cyc[$];

  assign rx_line = loop_en ? tx_serial : rx_drv;

  uart_transceiver #(.CLKS_PER_BIT(CPB)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .tx_data_valid (tx_data_valid),
    .tx_byte       (tx_byte),
    .tx_active     (tx_active),
    .tx_serial     (tx_serial),
    .tx_done       (tx_done),
    .rx_serial     (rx_line),
    .rx_data_valid (rx_data_valid),
    .rx_byte       (rx_byte)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Every cycle with rx_data_valid high is recorded, so a stretched pulse
  // shows up as an extra entry.
  always @(negedge clk) begin
    if (rx_data_valid) begin
      rx_got.push_back(rx_byte);
      rx_got_cyc.push_back(cyc);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  function automatic logic [FL-1:0] frame_wave(input logic [7:0] b);
    logic [FL-1:0] w;
    for (int i = 0; i < int'(FL); i++) begin
      int k;
      k = i / int'(CPB);
      if (k == 0)      w[i] = 1'b0;
      else if (k <= 8) w[i] = b[k-1];
      else             w[i] = 1'b1;
    end
    return w;
  endfunction

  task automatic send_tx(input logic [7:0] b);
    @(negedge clk);
    tx_byte = b;
    tx_data_valid = 1'b1;
    tx_exp.push_back(b);
    @(negedge clk);
    tx_data_valid = 1'b0;
  endtask

  // Samples one frame starting the cycle after acceptance; optionally pulses
  // tx_data_valid with another byte at sample index inject_at.
  task automatic capture_tx(input int inject_at, input logic [7:0] inject_byte,
                            output logic [FL-1:0] ser, output logic [FL-1:0] act,
                            output logic [FL-1:0] dn, output int done_cyc);
    done_cyc = -100000;
    for (int i = 0; i < int'(FL); i++) begin
      if (i > 0) @(negedge clk);
      ser[i] = tx_serial;
      act[i] = tx_active;
      dn[i]  = tx_done;
      if (tx_done) done_cyc = cyc;
      if (i == inject_at) begin
        tx_byte = inject_byte;
        tx_data_valid = 1'b1;
      end else if (i == inject_at + 1) begin
        tx_data_valid = 1'b0;
      end
    end
  endtask

  task automatic rx_send(input logic [7:0] b, input int extra_start);
    rx_exp.push_back(b);
    rx_drv = 1'b0;
    repeat (int'(CPB) + extra_start) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      rx_drv = b[k];
      repeat (CPB) @(negedge clk);
    end
    rx_drv = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic test_reset;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (tx_serial !== 1'b1) begin failures++; $display("FAIL reset_tx_serial got=%b exp=1", tx_serial); end
    checks++; if (tx_active !== 1'b0) begin failures++; $display("FAIL reset_tx_active got=%b exp=0", tx_active); end
    checks++; if (tx_done !== 1'b0) begin failures++; $display("FAIL reset_tx_done got=%b exp=0", tx_done); end
    checks++; if (rx_data_valid !== 1'b0) begin failures++; $display("FAIL reset_rx_valid got=%b exp=0", rx_data_valid); end
    checks++; if (rx_byte !== 8'h00) begin failures++; $display("FAIL reset_rx_byte got=%h exp=00", rx_byte); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_tx_single;
    logic [FL-1:0] ser, act, dn;
    logic [7:0] e;
    int dc;
    send_tx(8'hAB);
    capture_tx(-5, 8'h00, ser, act, dn, dc);
    e = tx_exp.pop_front();
    checks++; if (ser !== frame_wave(e)) begin failures++; $display("FAIL tx_single_wave got=%h exp=%h", ser, frame_wave(e)); end
    checks++; if (act !== ACT_EXP) begin failures++; $display("FAIL tx_single_active got=%h exp=%h", act, ACT_EXP); end
    checks++; if (dn !== DONE_EXP) begin failures++; $display("FAIL tx_single_done got=%h exp=%h", dn, DONE_EXP); end
    repeat (3) @(negedge clk);
    checks++; if ({tx_serial, tx_active, tx_done} !== 3'b100) begin failures++; $display("FAIL tx_single_idle got=%b exp=100", {tx_serial, tx_active, tx_done}); end
  endtask

  task automatic test_tx_back_to_back;
    logic [FL-1:0] ser, act, dn;
    logic [7:0] e;
    logic [7:0] seq [2];
    int dc;
    seq[0] = 8'h00;
    seq[1] = 8'hFF;
    for (int n = 0; n < 2; n++) begin
      send_tx(seq[n]);
      capture_tx(-5, 8'h00, ser, act, dn, dc);
      e = tx_exp.pop_front();
      checks++; if (ser !== frame_wave(e)) begin failures++; $display("FAIL tx_b2b_wave[%0d] got=%h exp=%h", n, ser, frame_wave(e)); end
      checks++; if (act !== ACT_EXP) begin failures++; $display("FAIL tx_b2b_active[%0d] got=%h exp=%h", n, act, ACT_EXP); end
      checks++; if (dn !== DONE_EXP) begin failures++; $display("FAIL tx_b2b_done[%0d] got=%h exp=%h", n, dn, DONE_EXP); end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_tx_ignore;
    logic [FL-1:0] ser, act, dn;
    logic [7:0] e;
    int dc;
    send_tx(8'h96);
    capture_tx(40, 8'h5A, ser, act, dn, dc);
    e = tx_exp.pop_front();
    checks++; if (ser !== frame_wave(e)) begin failures++; $display("FAIL tx_ignore_wave got=%h exp=%h", ser, frame_wave(e)); end
    checks++; if (dn !== DONE_EXP) begin failures++; $display("FAIL tx_ignore_done got=%h exp=%h", dn, DONE_EXP); end
    repeat (4) @(negedge clk);
    checks++; if ({tx_serial, tx_active} !== 2'b10) begin failures++; $display("FAIL tx_ignore_idle got=%b exp=10", {tx_serial, tx_active}); end
  endtask

  task automatic test_rx_single;
    logic [7:0] e;
    rx_got.delete(); rx_got_cyc.delete();
    rx_send(8'h3F, 2);
    repeat (4) @(negedge clk);
    e = rx_exp.pop_front();
    checks++; if (rx_got.size() !== 1) begin failures++; $display("FAIL rx_single_pulses got=%0d exp=1", rx_got.size()); end
    if (rx_got.size() > 0) begin
      checks++; if (rx_got[0] !== e) begin failures++; $display("FAIL rx_single_byte got=%h exp=%h", rx_got[0], e); end
    end
    checks++; if (rx_byte !== e) begin failures++; $display("FAIL rx_single_hold got=%h exp=%h", rx_byte, e); end
  endtask

  task automatic test_rx_glitch;
    logic [7:0] e;
    rx_got.delete(); rx_got_cyc.delete();
    rx_drv = 1'b0;
    repeat (CPB / 4) @(negedge clk);
    rx_drv = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    checks++; if (rx_got.size() !== 0) begin failures++; $display("FAIL rx_glitch_pulses got=%0d exp=0", rx_got.size()); end
    rx_send(8'hA5, 0);
    repeat (4) @(negedge clk);
    e = rx_exp.pop_front();
    checks++; if (rx_got.size() !== 1) begin failures++; $display("FAIL rx_after_glitch_pulses got=%0d exp=1", rx_got.size()); end
    if (rx_got.size() > 0) begin
      checks++; if (rx_got[0] !== e) begin failures++; $display("FAIL rx_after_glitch_byte got=%h exp=%h", rx_got[0], e); end
    end
  endtask

  task automatic test_rx_back_to_back;
    logic [7:0] e;
    rx_got.delete(); rx_got_cyc.delete();
    rx_send(8'h55, 0);
    rx_send(8'hAA, 0);
    repeat (4) @(negedge clk);
    checks++; if (rx_got.size() !== 2) begin failures++; $display("FAIL rx_b2b_pulses got=%0d exp=2", rx_got.size()); end
    for (int n = 0; n < 2; n++) begin
      e = rx_exp.pop_front();
      if (rx_got.size() > n) begin
        checks++; if (rx_got[n] !== e) begin failures++; $display("FAIL rx_b2b_byte[%0d] got=%h exp=%h", n, rx_got[n], e); end
      end
    end
  endtask

  task automatic test_rx_line_low;
    logic [7:0] e;
    rx_got.delete(); rx_got_cyc.delete();
    rx_drv = 1'b0;
    repeat (30 * CPB) @(negedge clk);
    checks++; if (rx_got.size() !== 1) begin failures++; $display("FAIL rx_low_pulses got=%0d exp=1", rx_got.size()); end
    if (rx_got.size() > 0) begin
      checks++; if (rx_got[0] !== 8'h00) begin failures++; $display("FAIL rx_low_byte got=%h exp=00", rx_got[0]); end
    end
    rx_drv = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    rx_got.delete(); rx_got_cyc.delete();
    rx_send(8'h3C, 0);
    repeat (4) @(negedge clk);
    e = rx_exp.pop_front();
    checks++; if (rx_got.size() !== 1 || rx_got[0] !== e) begin failures++; $display("FAIL rx_low_rearm got=%0d/%h exp=1/%h", rx_got.size(), rx_byte, e); end
  endtask

  task automatic test_reset_mid_tx;
    logic [FL-1:0] ser, act, dn;
    logic [7:0] e;
    int dc, done_seen;
    send_tx(8'hC3);
    repeat (3 * CPB) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if ({tx_serial, tx_active, tx_done} !== 3'b100) begin failures++; $display("FAIL tx_rst_mid got=%b exp=100", {tx_serial, tx_active, tx_done}); end
    void'(tx_exp.pop_back());
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < int'(12 * CPB); i++) begin
      @(negedge clk);
      if (tx_done || !tx_serial) done_seen++;
    end
    checks++; if (done_seen !== 0) begin failures++; $display("FAIL tx_rst_residue got=%0d exp=0", done_seen); end
    send_tx(8'hC3);
    capture_tx(-5, 8'h00, ser, act, dn, dc);
    e = tx_exp.pop_front();
    checks++; if (ser !== frame_wave(e)) begin failures++; $display("FAIL tx_rst_after_wave got=%h exp=%h", ser, frame_wave(e)); end
    checks++; if (dn !== DONE_EXP) begin failures++; $display("FAIL tx_rst_after_done got=%h exp=%h", dn, DONE_EXP); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid_rx;
    logic [7:0] b;
    logic [7:0] e;
    b = 8'h81;
    rx_got.delete(); rx_got_cyc.delete();
    rx_drv = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      rx_drv = b[k];
      repeat (CPB) @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    checks++; if ({rx_data_valid, rx_byte} !== 9'h000) begin failures++; $display("FAIL rx_rst_mid got=%b/%h exp=0/00", rx_data_valid, rx_byte); end
    rx_drv = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (12 * CPB) @(negedge clk);
    checks++; if (rx_got.size() !== 0) begin failures++; $display("FAIL rx_rst_residue got=%0d exp=0", rx_got.size()); end
    rx_send(b, 0);
    repeat (4) @(negedge clk);
    e = rx_exp.pop_front();
    checks++; if (rx_got.size() !== 1 || rx_byte !== e) begin failures++; $display("FAIL rx_rst_after got=%0d/%h exp=1/%h", rx_got.size(), rx_byte, e); end
  endtask

  task automatic test_concurrent;
    logic [FL-1:0] ser, act, dn;
    logic [7:0] e;
    int dc;
    rx_got.delete(); rx_got_cyc.delete();
    fork
      begin
        send_tx(8'h3C);
        capture_tx(-5, 8'h00, ser, act, dn, dc);
      end
      rx_send(8'hC5, 3);
    join
    repeat (4) @(negedge clk);
    e = tx_exp.pop_front();
    checks++; if (ser !== frame_wave(e)) begin failures++; $display("FAIL conc_tx_wave got=%h exp=%h", ser, frame_wave(e)); end
    e = rx_exp.pop_front();
    checks++; if (rx_got.size() !== 1 || rx_byte !== e) begin failures++; $display("FAIL conc_rx got=%0d/%h exp=1/%h", rx_got.size(), rx_byte, e); end
  endtask

  task automatic test_loopback;
    logic [FL-1:0] ser, act, dn;
    logic [7:0] e;
    logic [7:0] seq [3];
    int dc, diff;
    seq[0] = 8'h00;
    seq[1] = 8'hFF;
    seq[2] = 8'h5A;
    loop_en = 1'b1;
    repeat (4) @(negedge clk);
    for (int n = 0; n < 3; n++) begin
      rx_got.delete(); rx_got_cyc.delete();
      rx_exp.push_back(seq[n]);
      send_tx(seq[n]);
      capture_tx(-5, 8'h00, ser, act, dn, dc);
      repeat (4) @(negedge clk);
      e = tx_exp.pop_front();
      checks++; if (ser !== frame_wave(e)) begin failures++; $display("FAIL loop_tx_wave[%0d] got=%h exp=%h", n, ser, frame_wave(e)); end
      e = rx_exp.pop_front();
      checks++; if (rx_got.size() !== 1) begin failures++; $display("FAIL loop_rx_pulses[%0d] got=%0d exp=1", n, rx_got.size()); end
      if (rx_got.size() > 0) begin
        checks++; if (rx_got[0] !== e) begin failures++; $display("FAIL loop_rx_byte[%0d] got=%h exp=%h", n, rx_got[0], e); end
        diff = rx_got_cyc[0] - dc;
        if (diff < 0) diff = -diff;
        checks++; if (diff > int'(CPB)) begin failures++; $display("FAIL loop_timing[%0d] got=%0d exp<=%0d", n, diff, CPB); end
      end
    end
    loop_en = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_tx_single;
    test_tx_back_to_back;
    test_tx_ignore;
    test_rx_single;
    test_rx_glitch;
    test_rx_back_to_back;
    test_rx_line_low;
    test_reset_mid_tx;
    test_reset_mid_rx;
    test_concurrent;
    test_loopback;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
